// File: rtl/mips_ctl_pkg.sv
// Shared control-unit constants: next-state control codes and well-known control states.
// Used by the sequencer, the control ROM and the instruction-to-state encoder.
package mips_ctl_pkg;

  localparam int unsigned StateW = 7;

  typedef enum logic [2:0] {
    NsInc    = 3'd0,
    NsDecode = 3'd1,
    NsJump   = 3'd2,
    NsCond   = 3'd3,
    NsWait   = 3'd4,
    NsFetch  = 3'd5,
    NsCall   = 3'd6,
    NsRet    = 3'd7
  } ns_ctl_e;

  localparam logic [StateW-1:0] ResetState   = 7'd0;
  localparam logic [StateW-1:0] FetchState   = 7'd1;
  localparam logic [StateW-1:0] IllegalState = 7'd126;
  localparam logic [StateW-1:0] FaultState   = 7'd127;

endpackage

// File: rtl/moc_timeout_counter.sv
// Counts stalled cycles while waiting for memory-operation-complete; flags the cycle on
// which the wait budget is exhausted and self-clears on that cycle.
module moc_timeout_counter #(
  parameter int unsigned CntW    = 8,
  parameter int unsigned Timeout = 255
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The Timeout-th stalled cycle sees Timeout-1 already counted.
  assign expired_o = en_i && (cnt_q == CntW'(Timeout - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expired_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/microprogram_sequencer.sv
// Control-state register and next-state selection for the microprogrammed control unit,
// with memory-wait stalls, timeout fault and a single-level micro-subroutine return.
module microprogram_sequencer
  import mips_ctl_pkg::*;
#(
  parameter int unsigned ToW        = 8,
  parameter int unsigned MocTimeout = 255
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [StateW-1:0] state_sel_i,
  input  logic [2:0]        ns_ctl_i,
  input  logic [StateW-1:0] cr_target_i,
  input  logic              cond_i,
  input  logic              inv_i,
  input  logic              moc_i,
  input  logic              hold_i,
  output logic [StateW-1:0] state_o,
  output logic [StateW-1:0] ret_state_o,
  output logic              waiting_o,
  output logic              illegal_op_o,
  output logic              mem_fault_o
);

  logic [StateW-1:0] state_q, state_d;
  logic [StateW-1:0] ret_q, ret_d;
  logic              illegal_q, illegal_d;
  logic              fault_q, fault_d;
  logic [StateW-1:0] state_inc;
  logic              cnt_en, cnt_clr, cnt_expired;

  assign state_inc = state_q + 1'b1;
  assign waiting_o = (ns_ctl_i == NsWait) && !moc_i;

  // Counter only moves when the sequencer does; hold leaves it untouched.
  assign cnt_en  = !hold_i && (ns_ctl_i == NsWait) && !moc_i;
  assign cnt_clr = !hold_i && ((ns_ctl_i != NsWait) || moc_i);

  moc_timeout_counter #(
    .CntW    (ToW),
    .Timeout (MocTimeout)
  ) u_moc_timeout_counter (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .en_i      (cnt_en),
    .clr_i     (cnt_clr),
    .expired_o (cnt_expired)
  );

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    illegal_d = 1'b0;
    fault_d   = 1'b0;
    if (!hold_i) begin
      unique case (ns_ctl_i)
        NsInc:    state_d = state_inc;
        NsDecode: begin
          if (state_sel_i == '0) begin
            state_d   = IllegalState;
            illegal_d = 1'b1;
          end else begin
            state_d = state_sel_i;
          end
        end
        NsJump:   state_d = cr_target_i;
        NsCond:   state_d = (cond_i ^ inv_i) ? cr_target_i : state_inc;
        NsWait: begin
          // moc takes priority over a timeout landing on the same cycle.
          if (moc_i) begin
            state_d = state_inc;
          end else if (cnt_expired) begin
            state_d = FaultState;
            fault_d = 1'b1;
          end
        end
        NsFetch:  state_d = FetchState;
        NsCall: begin
          ret_d   = state_inc;
          state_d = cr_target_i;
        end
        NsRet:    state_d = ret_q;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ResetState;
      ret_q     <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  assign state_o      = state_q;
  assign ret_state_o  = ret_q;
  assign illegal_op_o = illegal_q;
  assign mem_fault_o  = fault_q;

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Directed test of the microprogram sequencer with hand-computed expected states.
module tb_microprogram_sequencer;
  import mips_ctl_pkg::*;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic [StateW-1:0] state_sel_i;
  logic [2:0]        ns_ctl_i;
  logic [StateW-1:0] cr_target_i;
  logic              cond_i, inv_i, moc_i, hold_i;
  logic [StateW-1:0] state_o, ret_state_o;
  logic              waiting_o, illegal_op_o, mem_fault_o;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  microprogram_sequencer u_dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .state_sel_i  (state_sel_i),
    .ns_ctl_i     (ns_ctl_i),
    .cr_target_i  (cr_target_i),
    .cond_i       (cond_i),
    .inv_i        (inv_i),
    .moc_i        (moc_i),
    .hold_i       (hold_i),
    .state_o      (state_o),
    .ret_state_o  (ret_state_o),
    .waiting_o    (waiting_o),
    .illegal_op_o (illegal_op_o),
    .mem_fault_o  (mem_fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs may be changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic jump_to(input logic [StateW-1:0] tgt);
    ns_ctl_i    = NsJump;
    cr_target_i = tgt;
    tick();
  endtask

  initial begin
    reset_ni    = 1'b0;
    state_sel_i = '0;
    ns_ctl_i    = NsInc;
    cr_target_i = '0;
    cond_i      = 1'b0;
    inv_i       = 1'b0;
    moc_i       = 1'b0;
    hold_i      = 1'b0;
    #12;
    check_eq("rst_state", 32'(state_o), 32'h00);
    check_eq("rst_ret", 32'(ret_state_o), 32'h00);
    check_eq("rst_illegal", 32'(illegal_op_o), 32'h0);
    check_eq("rst_fault", 32'(mem_fault_o), 32'h0);
    reset_ni = 1'b1;
    #1;

    // Reach 0x55, call out of it, then async reset mid-call.
    jump_to(7'h55);
    check_eq("jump_55", 32'(state_o), 32'h55);
    ns_ctl_i = NsCall; cr_target_i = 7'h60;
    tick();
    check_eq("call_60", 32'(state_o), 32'h60);
    check_eq("call_ret56", 32'(ret_state_o), 32'h56);
    #2 reset_ni = 1'b0;
    #1;
    check_eq("async_rst_state", 32'(state_o), 32'h00);
    check_eq("async_rst_ret", 32'(ret_state_o), 32'h00);
    @(negedge clk_i);
    reset_ni = 1'b1;
    ns_ctl_i = NsInc;
    tick();
    check_eq("inc_1", 32'(state_o), 32'h01);
    tick();
    check_eq("inc_2", 32'(state_o), 32'h02);

    jump_to(7'h7F);
    ns_ctl_i = NsInc;
    tick();
    check_eq("inc_wrap", 32'(state_o), 32'h00);

    // DECODE
    ns_ctl_i = NsDecode; state_sel_i = 7'd17;
    tick();
    check_eq("decode_17", 32'(state_o), 32'd17);
    check_eq("decode_17_illegal", 32'(illegal_op_o), 32'h0);
    state_sel_i = 7'd0;
    tick();
    check_eq("decode_0", 32'(state_o), 32'd126);
    check_eq("decode_0_illegal", 32'(illegal_op_o), 32'h1);
    ns_ctl_i = NsInc;
    tick();
    check_eq("illegal_pulse_end", 32'(illegal_op_o), 32'h0);
    check_eq("inc_127", 32'(state_o), 32'd127);

    // COND
    jump_to(7'h10);
    ns_ctl_i = NsCond; cond_i = 1'b1; inv_i = 1'b0; cr_target_i = 7'h20;
    tick();
    check_eq("cond_taken", 32'(state_o), 32'h20);
    jump_to(7'h10);
    ns_ctl_i = NsCond; cond_i = 1'b1; inv_i = 1'b1; cr_target_i = 7'h20;
    tick();
    check_eq("cond_inv_not_taken", 32'(state_o), 32'h11);
    cond_i = 1'b0; inv_i = 1'b1;
    tick();
    check_eq("cond_inv_taken", 32'(state_o), 32'h20);
    cond_i = 1'b0; inv_i = 1'b0;

    ns_ctl_i = NsFetch;
    tick();
    check_eq("fetch", 32'(state_o), 32'h01);

    // WAIT, moc after 10 cycles
    jump_to(7'h08);
    ns_ctl_i = NsWait; moc_i = 1'b0;
    #1;
    check_eq("waiting_hi", 32'(waiting_o), 32'h1);
    for (int i = 0; i < 10; i++) tick();
    check_eq("wait_hold", 32'(state_o), 32'h08);
    moc_i = 1'b1;
    #1;
    check_eq("waiting_lo", 32'(waiting_o), 32'h0);
    tick();
    check_eq("wait_done", 32'(state_o), 32'h09);

    // WAIT timeout
    moc_i = 1'b0;
    jump_to(7'h08);
    ns_ctl_i = NsWait;
    for (int i = 0; i < 254; i++) tick();
    check_eq("to_254_state", 32'(state_o), 32'h08);
    check_eq("to_254_fault", 32'(mem_fault_o), 32'h0);
    tick();
    check_eq("to_255_state", 32'(state_o), 32'd127);
    check_eq("to_255_fault", 32'(mem_fault_o), 32'h1);
    ns_ctl_i = NsInc;
    tick();
    check_eq("fault_pulse_end", 32'(mem_fault_o), 32'h0);

    // moc arrives on the 255th cycle
    jump_to(7'h08);
    ns_ctl_i = NsWait;
    for (int i = 0; i < 254; i++) tick();
    moc_i = 1'b1;
    tick();
    check_eq("moc_255_state", 32'(state_o), 32'h09);
    check_eq("moc_255_fault", 32'(mem_fault_o), 32'h0);
    moc_i = 1'b0;

    // Hold freezes the wait counter: 200 + hold + 54 stalls must not fault.
    jump_to(7'h08);
    ns_ctl_i = NsWait;
    for (int i = 0; i < 200; i++) tick();
    hold_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    hold_i = 1'b0;
    for (int i = 0; i < 54; i++) tick();
    check_eq("hold_wait_state", 32'(state_o), 32'h08);
    tick();
    check_eq("hold_wait_fault", 32'(mem_fault_o), 32'h1);

    // CALL / RET with hold mid-sequence
    jump_to(7'h30);
    ns_ctl_i = NsCall; cr_target_i = 7'h40;
    tick();
    check_eq("call_40", 32'(state_o), 32'h40);
    check_eq("call_ret31", 32'(ret_state_o), 32'h31);
    hold_i = 1'b1; ns_ctl_i = NsDecode; state_sel_i = 7'd0;
    tick();
    check_eq("hold_state", 32'(state_o), 32'h40);
    check_eq("hold_illegal", 32'(illegal_op_o), 32'h0);
    ns_ctl_i = NsCall; cr_target_i = 7'h50;
    tick();
    check_eq("hold_ret", 32'(ret_state_o), 32'h31);
    ns_ctl_i = NsWait; moc_i = 1'b0;
    #1;
    check_eq("hold_waiting", 32'(waiting_o), 32'h1);
    hold_i = 1'b0; ns_ctl_i = NsRet;
    tick();
    check_eq("ret_31", 32'(state_o), 32'h31);

    // Async reset mid-wait
    jump_to(7'h08);
    ns_ctl_i = NsWait;
    for (int i = 0; i < 3; i++) tick();
    #2 reset_ni = 1'b0;
    #1;
    check_eq("rst_mid_wait", 32'(state_o), 32'h00);
    @(negedge clk_i);
    reset_ni = 1'b1;
    ns_ctl_i = NsInc;
    tick();
    check_eq("post_rst_inc", 32'(state_o), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
